// File: rtl/video_sprite_eval_pkg.sv
// Shared types and constants for the sprite evaluation block.
package video_sprite_signals;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN_Y,
    S_COPY,
    S_OVF_SCAN,
    S_DONE
  } state_e;

  localparam logic [7:0] C_sec_fill         = 8'hFF;
  localparam int         C_bytes_per_sprite = 4;

endpackage

// File: rtl/video_sprite_range.sv
// Scanline range test: the sprite covers I_line when (I_line - Y) mod 512 is below the sprite height.
module video_sprite_range (
  input  logic [8:0] I_line,
  input  logic [7:0] I_y,
  input  logic       I_tall,
  output logic       O_in_range
);

  logic [8:0] diff;

  assign diff       = I_line - {1'b0, I_y};
  assign O_in_range = I_tall ? (diff < 9'd16) : (diff < 9'd8);

endmodule

// File: rtl/video_sprite_eval.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans primary OAM and
// copies up to P_max_sprites in-range sprites, then flags overflow.
// Optional VIDEO_SPRITE_OVFBUG_EN reproduces the overflow-scan byte-index quirk
// (byte index advances together with sprite index on out-of-range tests).
module video_sprite_eval
  import video_sprite_signals::*;
#(
  parameter int P_max_sprites = 8,
  parameter int P_oam_entries = 64
) (
  input  logic                                 I_clock,
  input  logic                                 I_reset,
  input  logic                                 I_start,
  input  logic [8:0]                           I_line,
  input  logic                                 I_tall,
  output logic [$clog2(4*P_oam_entries)-1:0]   O_oam_addr,
  input  logic [7:0]                           I_oam_data,
  output logic [$clog2(4*P_max_sprites)-1:0]   O_sec_addr,
  output logic                                 O_sec_wren,
  output logic [7:0]                           O_sec_data,
  output logic                                 O_busy,
  output logic                                 O_done,
  output logic [$clog2(P_max_sprites):0]       O_count,
  output logic                                 O_overflow,
  output logic                                 O_sprite0
);

  localparam int N_W   = $clog2(P_oam_entries);
  localparam int SL_W  = $clog2(P_max_sprites);
  localparam int SA_W  = $clog2(C_bytes_per_sprite*P_max_sprites);
  localparam int CNT_W = SL_W + 1;

  state_e           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [1:0]       m_q, m_d;
  logic             ph_q, ph_d;      // 0 = address phase, 1 = data phase
  logic [SA_W-1:0]  clr_q, clr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             s0_q, s0_d;

  logic in_range, last_n, cnt_full;

  video_sprite_range u_range (
    .I_line     (I_line),
    .I_y        (I_oam_data),
    .I_tall     (I_tall),
    .O_in_range (in_range)
  );

  assign last_n   = (n_q == N_W'(P_oam_entries - 1));
  assign cnt_full = (cnt_q == CNT_W'(P_max_sprites));

  assign O_oam_addr = {n_q, m_q};
  assign O_count    = cnt_q;
  assign O_overflow = ovf_q;
  assign O_sprite0  = s0_q;

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      ph_q    <= 1'b0;
      clr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      s0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      ph_q    <= ph_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      s0_q    <= s0_d;
    end
  end

  // Next-state: every OAM byte costs an address clock then a data clock.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    ph_d    = ph_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    s0_d    = s0_q;
    case (state_q)
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == SA_W'(C_bytes_per_sprite*P_max_sprites - 1)) state_d = S_SCAN_Y;
      end
      S_SCAN_Y: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (in_range && !cnt_full) begin
            state_d = S_COPY;
            m_d     = 2'd1;
          end else begin
            n_d = n_q + 1'b1;
            if (last_n) state_d = S_DONE;
          end
        end
      end
      S_COPY: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (m_q == 2'd3) begin
            m_d   = 2'd0;
            n_d   = n_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (n_q == '0) s0_d = 1'b1;
            if (last_n)                                        state_d = S_DONE;
            else if (cnt_q == CNT_W'(P_max_sprites - 1))       state_d = S_OVF_SCAN;
            else                                               state_d = S_SCAN_Y;
          end else begin
            m_d = m_q + 1'b1;
          end
        end
      end
      S_OVF_SCAN: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (in_range) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            n_d = n_q + 1'b1;
`ifdef VIDEO_SPRITE_OVFBUG_EN
            m_d = m_q + 1'b1;
`endif
            if (last_n) state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
    // A start pulse restarts evaluation from any state.
    if (I_start) begin
      state_d = S_CLEAR;
      n_d     = '0;
      m_d     = '0;
      ph_d    = 1'b0;
      clr_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      s0_d    = 1'b0;
    end
  end

  // Outputs: secondary-OAM write port and status decoded from state.
  always_comb begin
    O_sec_wren = 1'b0;
    O_sec_addr = '0;
    O_sec_data = '0;
    O_busy     = 1'b0;
    O_done     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        O_busy     = 1'b1;
        O_sec_wren = 1'b1;
        O_sec_addr = clr_q;
        O_sec_data = C_sec_fill;
      end
      S_SCAN_Y: begin
        O_busy = 1'b1;
        if (ph_q && in_range && !cnt_full) begin
          O_sec_wren = 1'b1;
          O_sec_addr = {cnt_q[SL_W-1:0], 2'b00};
          O_sec_data = I_oam_data;
        end
      end
      S_COPY: begin
        O_busy = 1'b1;
        if (ph_q) begin
          O_sec_wren = 1'b1;
          O_sec_addr = {cnt_q[SL_W-1:0], m_q};
          O_sec_data = I_oam_data;
        end
      end
      S_OVF_SCAN: O_busy = 1'b1;
      S_DONE:     O_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_video_sprite_eval.sv
// Scoreboard bench: stimulus pushes expected secondary writes and completion
// status; a monitor pops and compares as the DUT presents them.
module tb_video_sprite_eval;

  logic       clk = 1'b0;
  logic       rst, start, tall;
  logic [8:0] line;

  logic [7:0] oam [256];
  logic [7:0] rd1, rd2;

  logic [7:0] oa1, oa2;
  logic [4:0] sa1;
  logic [5:0] sa2;
  logic       wr1, wr2, busy1, busy2, done1, done2, ovf1, ovf2, s01, s02;
  logic [7:0] sd1, sd2;
  logic [3:0] cnt1;
  logic [4:0] cnt2;

  always #5 clk = ~clk;

  video_sprite_eval dut1 (
    .I_clock(clk), .I_reset(rst), .I_start(start), .I_line(line), .I_tall(tall),
    .O_oam_addr(oa1), .I_oam_data(rd1), .O_sec_addr(sa1), .O_sec_wren(wr1),
    .O_sec_data(sd1), .O_busy(busy1), .O_done(done1), .O_count(cnt1),
    .O_overflow(ovf1), .O_sprite0(s01)
  );

  video_sprite_eval #(.P_max_sprites(16), .P_oam_entries(64)) dut2 (
    .I_clock(clk), .I_reset(rst), .I_start(start), .I_line(line), .I_tall(tall),
    .O_oam_addr(oa2), .I_oam_data(rd2), .O_sec_addr(sa2), .O_sec_wren(wr2),
    .O_sec_data(sd2), .O_busy(busy2), .O_done(done2), .O_count(cnt2),
    .O_overflow(ovf2), .O_sprite0(s02)
  );

  // Synchronous primary OAM: data valid the clock after the address.
  always @(posedge clk) begin
    rd1 <= oam[oa1];
    rd2 <= oam[oa2];
  end

  typedef struct packed { logic [4:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [3:0] cnt; logic ovf; logic s0; logic [15:0] busy; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  wr_t we;
  dn_t de;
  int  n_chk = 0, n_pass = 0, bcnt = 0;
  bit  chk_wr = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Monitor: busy-cycle counting, secondary writes, completion status.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || start) bcnt = 0;
      else if (busy1)   bcnt++;
      if (wr1 && chk_wr) begin
        if (wq.size() == 0) chk("unexpected_sec_write", 32'(sa1), 32'hFFFF);
        else begin
          we = wq.pop_front();
          chk("sec_addr", 32'(sa1), 32'(we.a));
          chk("sec_data", 32'(sd1), 32'(we.d));
        end
      end
      if (done1) begin
        if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          de = dq.pop_front();
          chk("done_count",    32'(cnt1),  32'(de.cnt));
          chk("done_overflow", 32'(ovf1),  32'(de.ovf));
          chk("done_sprite0",  32'(s01),   32'(de.s0));
          chk("done_busy_clk", 32'(bcnt),  32'(de.busy));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
  endtask

  task automatic set_spr(input int s, input logic [7:0] y);
    oam[4*s]   = y;
    oam[4*s+1] = 8'(s);
    oam[4*s+2] = 8'(s) ^ 8'h5A;
    oam[4*s+3] = 8'(3*s + 1);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 32; i++) wq.push_back(wr_t'{a: 5'(i), d: 8'hFF});
  endtask

  task automatic push_slot(input int slot, input int s);
    for (int b = 0; b < 4; b++) wq.push_back(wr_t'{a: 5'(slot*4 + b), d: oam[4*s + b]});
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (!done1 && k < budget);
    if (!done1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [8:0] ln, input logic t, input dn_t exp);
    line = ln; tall = t;
    dq.push_back(exp);
    pulse_start();
    wait_done1(2000);
    tick(); tick(); tick();
    chk("count_hold", 32'(cnt1), 32'(exp.cnt));
    chk("ovf_hold",   32'(ovf1), 32'(exp.ovf));
    chk("idle_busy",  32'(busy1), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, bad;
    rst = 1'b1; start = 1'b0; line = '0; tall = 1'b0;
    clear_oam();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy",     32'(busy1), 0);
    chk("rst_done",     32'(done1), 0);
    chk("rst_wren",     32'(wr1),   0);
    chk("rst_count",    32'(cnt1),  0);
    chk("rst_overflow", 32'(ovf1),  0);
    chk("rst_sprite0",  32'(s01),   0);
    chk("rst_oam_addr", 32'(oa1),   0);
    chk("rst_sec_addr", 32'(sa1),   0);
    chk("rst_sec_data", 32'(sd1),   0);
    tick(); rst = 1'b0; tick();

    // Nothing in range.
    push_clear();
    run(9'd10, 1'b0, dn_t'{cnt: 4'd0, ovf: 1'b0, s0: 1'b0, busy: 16'd160});

    // Sprites 0 and 5 in range.
    set_spr(0, 8'd8); set_spr(5, 8'd8);
    push_clear(); push_slot(0, 0); push_slot(1, 5);
    run(9'd10, 1'b0, dn_t'{cnt: 4'd2, ovf: 1'b0, s0: 1'b1, busy: 16'd172});

    // Height selection: diff 15 is in range only for tall sprites.
    clear_oam(); set_spr(3, 8'd2);
    push_clear();
    run(9'd17, 1'b0, dn_t'{cnt: 4'd0, ovf: 1'b0, s0: 1'b0, busy: 16'd160});
    push_clear(); push_slot(0, 3);
    run(9'd17, 1'b1, dn_t'{cnt: 4'd1, ovf: 1'b0, s0: 1'b0, busy: 16'd166});

    // Boundary: diff 8 out, diff 7 in, diff 16 out.
    clear_oam(); set_spr(1, 8'd8); set_spr(2, 8'd9); set_spr(4, 8'd0);
    push_clear(); push_slot(0, 2);
    run(9'd16, 1'b0, dn_t'{cnt: 4'd1, ovf: 1'b0, s0: 1'b0, busy: 16'd166});

    // Nine in range: eight slots fill, ninth flags overflow; 16-slot DUT takes all nine.
    clear_oam();
    for (int s = 0; s < 9; s++) set_spr(s, 8'd8);
    push_clear();
    for (int s = 0; s < 8; s++) push_slot(s, s);
    run(9'd10, 1'b0, dn_t'{cnt: 4'd8, ovf: 1'b1, s0: 1'b1, busy: 16'd98});
    k = 0;
    while (!done2 && k < 1000) begin @(negedge clk); k++; end
    chk("p16_done_seen", 32'(done2), 32'd1);
    chk("p16_count",     32'(cnt2),  32'd9);
    chk("p16_overflow",  32'(ovf2),  32'd0);
    tick();

    // Overflow-scan quirk: sprite 8 out of range, then sprite 9 byte 1 matches the line.
    clear_oam();
    for (int s = 0; s < 8; s++) set_spr(s, 8'd8);
    oam[4*9+1] = 8'd10;
    push_clear();
    for (int s = 0; s < 8; s++) push_slot(s, s);
`ifdef VIDEO_SPRITE_OVFBUG_EN
    run(9'd10, 1'b0, dn_t'{cnt: 4'd8, ovf: 1'b1, s0: 1'b1, busy: 16'd100});
`else
    run(9'd10, 1'b0, dn_t'{cnt: 4'd8, ovf: 1'b0, s0: 1'b1, busy: 16'd208});
`endif

    // Restart during the copy of sprite 5 (slot 1).
    clear_oam(); set_spr(0, 8'd8); set_spr(5, 8'd8);
    chk_wr = 1'b0;
    line = 9'd10; tall = 1'b0;
    dq.push_back(dn_t'{cnt: 4'd2, ovf: 1'b0, s0: 1'b1, busy: 16'd172});
    pulse_start();
    k = 0;
    do begin @(negedge clk); k++; end while (!(wr1 && sa1 == 5'd4 && sd1 == 8'd8) && k < 400);
    chk("slot1_y_write_seen", 32'(wr1 && sa1 == 5'd4), 32'd1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("restart_count",   32'(cnt1),  0);
    chk("restart_sprite0", 32'(s01),   0);
    chk("restart_wren",    32'(wr1),   1);
    chk("restart_addr",    32'(sa1),   0);
    chk("restart_data",    32'(sd1),   32'hFF);
    wait_done1(2000);
    tick();

    // Reset during CLEAR abandons the evaluation.
    pulse_start();
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_wren",  32'(wr1),   0);
    chk("rst_mid_busy",  32'(busy1), 0);
    chk("rst_mid_count", 32'(cnt1),  0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr1 || done1 || busy1) bad++;
    end
    chk("quiet_after_reset", 32'(bad), 0);

    // Reset dominates a coincident start.
    tick();
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_vs_start_busy", 32'(busy1), 0);
    chk("rst_vs_start_wren", 32'(wr1),   0);
    chk_wr = 1'b1;

    chk("write_queue_drained", 32'(wq.size()), 0);
    chk("done_queue_drained",  32'(dq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
